// File: rtl/rx_frm_pkg.sv
// Shared constants, FSM states and CRC-16-CCITT helper for the RX deframer.
// Hold depth follows RX_DEFRM_CRC_EN: 3 with a CRC trailer, 1 without.
package rx_frm_pkg;

    localparam logic [7:0]  SOF_CHAR  = 8'hFB;
    localparam logic [7:0]  EOF_CHAR  = 8'hFD;
    localparam logic [7:0]  IDLE_CHAR = 8'hBC;
    localparam int unsigned MAX_LEN   = 1518;
    localparam int unsigned LEN_W     = 11;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

`ifdef RX_DEFRM_CRC_EN
    localparam int unsigned HD = 3;
`else
    localparam int unsigned HD = 1;
`endif
    localparam int unsigned CNT_W = 2;

    typedef enum logic [0:0] {StIdle, StData} state_e;

    // MSB-first, non-reflected update of one byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_crc16_ccitt.sv
// Running CRC-16-CCITT over accepted frame bytes; clear has priority over enable.
module rx_crc16_ccitt
    import rx_frm_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (i_clear) begin
            crc_d = CRC_INIT;
        end else if (i_enable) begin
            crc_d = crc16_byte(crc_q, i_data);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/rx_frame_deframer.sv
// Finds SOF/EOF-delimited frames in the decoded 8b stream and emits payload with sop/eop/err.
// Define RX_DEFRM_CRC_EN to check and strip a 2-byte CRC-16-CCITT trailer.
module rx_frame_deframer
    import rx_frm_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_8b_data,
    input  logic        i_8b_datak,
    input  logic        i_comma_aligned,
    input  logic        i_disp_err,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_err,
    output logic [15:0] o_frm_cnt,
    output logic [15:0] o_err_cnt
);

    state_e               state_q, state_d;
    logic [HD-1:0][7:0]   hold_q, hold_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     len_q, len_d, len_inc;
    logic                 sop_pend_q, sop_pend_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
    logic [15:0]          frm_cnt_q, frm_cnt_d, err_cnt_q, err_cnt_d;
    logic                 is_idle, is_sof, is_eof, hold_full, end_bad;
    logic                 do_abort, do_start, do_finish, do_push;
    logic [7:0]           oldest;
    logic                 crc_bad;

    assign is_idle   = i_8b_datak && (i_8b_data == IDLE_CHAR);
    assign is_sof    = i_8b_datak && (i_8b_data == SOF_CHAR);
    assign is_eof    = i_8b_datak && (i_8b_data == EOF_CHAR);
    assign hold_full = (cnt_q == CNT_W'(HD));
    assign oldest    = (cnt_q == '0) ? 8'h00 : hold_q[0];
    assign len_inc   = len_q + 1'b1;

`ifdef RX_DEFRM_CRC_EN
    logic [15:0] crc;

    rx_crc16_ccitt u_crc (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (do_start),
        .i_enable (do_push),
        .i_data   (i_8b_data),
        .o_crc    (crc)
    );

    assign crc_bad = (crc != 16'h0000);
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sop_pend_d = sop_pend_q;
        data_d     = 8'h00;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        frm_cnt_d  = frm_cnt_q;
        err_cnt_d  = err_cnt_q;
        do_abort   = 1'b0;
        do_start   = 1'b0;
        do_finish  = 1'b0;
        do_push    = 1'b0;
        end_bad    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_comma_aligned && is_sof) do_start = 1'b1;
            end
            StData: begin
                if (!i_comma_aligned) begin
                    do_abort = 1'b1;
                end else if (is_idle) begin
                    do_abort = 1'b0;
                end else if (i_disp_err) begin
                    do_abort = 1'b1;
                end else if (i_8b_datak) begin
                    // SOF inside a frame closes the old one and opens a new one.
                    do_abort  = !is_eof;
                    do_start  = is_sof;
                    do_finish = is_eof;
                end else if (len_inc == LEN_W'(MAX_LEN + 1)) begin
                    do_abort = 1'b1;
                end else begin
                    do_push = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_abort || do_finish) begin
            state_d = StIdle;
            end_bad = do_abort || !hold_full || crc_bad;
            // A beat is owed if sop went out, or a complete frame ends normally.
            if (!sop_pend_q || (do_finish && hold_full)) begin
                valid_d = 1'b1;
                data_d  = oldest;
                sop_d   = sop_pend_q;
                eop_d   = 1'b1;
                err_d   = end_bad;
            end
            if (end_bad) begin
                err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            end else begin
                frm_cnt_d = (frm_cnt_q == 16'hFFFF) ? frm_cnt_q : frm_cnt_q + 16'd1;
            end
            cnt_d = '0;
        end

        if (do_start) begin
            state_d    = StData;
            cnt_d      = '0;
            len_d      = '0;
            sop_pend_d = 1'b1;
        end

        if (do_push) begin
            len_d = len_inc;
            if (hold_full) begin
                valid_d    = 1'b1;
                data_d     = hold_q[0];
                sop_d      = sop_pend_q;
                sop_pend_d = 1'b0;
                for (int i = 0; i < int'(HD) - 1; i++) hold_d[i] = hold_q[i+1];
                hold_d[HD-1] = i_8b_data;
            end else begin
                for (int i = 0; i < int'(HD); i++) begin
                    if (cnt_q == CNT_W'(i)) hold_d[i] = i_8b_data;
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            sop_pend_q <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
            frm_cnt_q  <= 16'h0000;
            err_cnt_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sop_pend_q <= sop_pend_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
            frm_cnt_q  <= frm_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_sop     = sop_q;
    assign o_eop     = eop_q;
    assign o_err     = err_q;
    assign o_frm_cnt = frm_cnt_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Bench for rx_frame_deframer: vector table, length/sync corner cases and random frames
// checked against a frame-level reference model (queue of frame bytes).
module tb_rx_frame_deframer;

    localparam logic [7:0] SOF_C  = 8'hFB;
    localparam logic [7:0] EOF_C  = 8'hFD;
    localparam logic [7:0] IDLE_C = 8'hBC;
    localparam int TB_MAX_LEN = 1518;
`ifdef RX_DEFRM_CRC_EN
    localparam int TB_HD = 3;
`else
    localparam int TB_HD = 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_8b_data = 8'h00;
    logic        i_8b_datak = 1'b0;
    logic        i_comma_aligned = 1'b0;
    logic        i_disp_err = 1'b0;
    logic [7:0]  o_data;
    logic        o_valid, o_sop, o_eop, o_err;
    logic [15:0] o_frm_cnt, o_err_cnt;

    rx_frame_deframer dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_8b_data       (i_8b_data),
        .i_8b_datak      (i_8b_datak),
        .i_comma_aligned (i_comma_aligned),
        .i_disp_err      (i_disp_err),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .o_sop           (o_sop),
        .o_eop           (o_eop),
        .o_err           (o_err),
        .o_frm_cnt       (o_frm_cnt),
        .o_err_cnt       (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: frame bytes so far, expected registered outputs after each char.
    logic [7:0]  fr[$];
    bit          in_fr = 0;
    logic        m_v, m_sop, m_eop, m_err;
    logic [7:0]  m_data;
    logic [15:0] m_frm = 16'd0, m_errc = 16'd0;

    function automatic logic [15:0] tb_crc(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                if (c[15] ^ q[i][b]) c = (c << 1) ^ 16'h1021;
                else c = c << 1;
            end
        end
        return c;
    endfunction

    function automatic void m_end(input bit abort);
        int n;
        bit sop_done, full, bad;
        n        = fr.size();
        sop_done = n > TB_HD;
        full     = n >= TB_HD;
        bad      = abort || !full;
`ifdef RX_DEFRM_CRC_EN
        if (!bad && tb_crc(fr) != 16'h0000) bad = 1;
`endif
        if (sop_done || (!abort && full)) begin
            m_v    = 1;
            m_data = fr[n-TB_HD];
            m_sop  = !sop_done;
            m_eop  = 1;
            m_err  = bad;
        end
        if (bad) begin
            if (m_errc != 16'hFFFF) m_errc++;
        end else if (m_frm != 16'hFFFF) begin
            m_frm++;
        end
        in_fr = 0;
        fr.delete();
    endfunction

    function automatic void model_step(input logic [7:0] d, input logic k, input logic al,
                                       input logic de);
        m_v = 0; m_data = 8'h00; m_sop = 0; m_eop = 0; m_err = 0;
        if (!in_fr) begin
            if (al && k && d == SOF_C) begin fr.delete(); in_fr = 1; end
        end else if (!al) begin
            m_end(1);
        end else if (k && d == IDLE_C) begin
            in_fr = 1;
        end else if (de) begin
            m_end(1);
        end else if (k) begin
            if (d == SOF_C) begin m_end(1); in_fr = 1; end
            else if (d == EOF_C) m_end(0);
            else m_end(1);
        end else if (fr.size() == TB_MAX_LEN) begin
            m_end(1);
        end else begin
            fr.push_back(d);
            if (fr.size() > TB_HD) begin
                m_v    = 1;
                m_data = fr[fr.size()-TB_HD-1];
                m_sop  = (fr.size() == TB_HD + 1);
            end
        end
    endfunction

    task automatic drive(input logic [7:0] d, input logic k, input logic al, input logic de);
        bit ok;
        i_8b_data = d; i_8b_datak = k; i_comma_aligned = al; i_disp_err = de;
        @(posedge i_clk);
        model_step(d, k, al, de);
        #1;
        nchk++;
        ok = (o_valid === m_v) && (o_frm_cnt === m_frm) && (o_err_cnt === m_errc) &&
             (!m_v || (o_data === m_data && o_sop === m_sop && o_eop === m_eop &&
                       o_err === m_err));
        if (!ok) begin
            nerr++;
            $display("FAIL model t=%0t got v=%b d=%h s=%b e=%b r=%b f=%0d ec=%0d want v=%b d=%h s=%b e=%b r=%b f=%0d ec=%0d",
                     $time, o_valid, o_data, o_sop, o_eop, o_err, o_frm_cnt, o_err_cnt,
                     m_v, m_data, m_sop, m_eop, m_err, m_frm, m_errc);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        nchk++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       k, al, de;
        logic       v;
        logic [7:0] od;
        logic       sop, eop, err;
        int         frm, errc;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [7:0] d, input logic k, input logic al,
                                input logic de, input logic v, input logic [7:0] od,
                                input logic sop, input logic eop, input logic err,
                                input int frm, input int errc);
        vec_t r;
        r.d = d; r.k = k; r.al = al; r.de = de; r.v = v; r.od = od;
        r.sop = sop; r.eop = eop; r.err = err; r.frm = frm; r.errc = errc;
        vecs.push_back(r);
    endfunction

    initial begin
        int beats, e0;
        bit last_ok;
        logic [7:0] pay[$];
        logic [15:0] c;
        int len, r;

        repeat (2) @(negedge i_clk);
        nchk++;
        if ({o_valid, o_sop, o_eop, o_err, o_data, o_frm_cnt, o_err_cnt} !== '0) begin
            nerr++;
            $display("FAIL reset got v=%b d=%h f=%0d ec=%0d want all zero",
                     o_valid, o_data, o_frm_cnt, o_err_cnt);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);

`ifndef RX_DEFRM_CRC_EN
        //  d     k al de  v  od     s  e  r  frm ec
        add(8'hBC,1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(8'hFB,1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(8'h11,0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(8'h22,0, 1, 0, 1, 8'h11, 1, 0, 0, 0, 0);
        add(8'h33,0, 1, 0, 1, 8'h22, 0, 0, 0, 0, 0);
        add(8'hFD,1, 1, 0, 1, 8'h33, 0, 1, 0, 1, 0);
        add(8'hFB,1, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        add(8'h11,0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        add(8'hBC,1, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        add(8'hBC,1, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        add(8'h22,0, 1, 0, 1, 8'h11, 1, 0, 0, 1, 0);
        add(8'hFD,1, 1, 0, 1, 8'h22, 0, 1, 0, 2, 0);
        add(8'hFB,1, 1, 0, 0, 8'h00, 0, 0, 0, 2, 0);
        add(8'hFD,1, 1, 0, 0, 8'h00, 0, 0, 0, 2, 1);
        add(8'hFB,1, 1, 0, 0, 8'h00, 0, 0, 0, 2, 1);
        add(8'h11,0, 1, 0, 0, 8'h00, 0, 0, 0, 2, 1);
        add(8'h22,0, 1, 0, 1, 8'h11, 1, 0, 0, 2, 1);
        add(8'h33,0, 1, 1, 1, 8'h22, 0, 1, 1, 2, 2);
        add(8'h44,0, 1, 0, 0, 8'h00, 0, 0, 0, 2, 2);
        add(8'hFB,1, 1, 0, 0, 8'h00, 0, 0, 0, 2, 2);
        add(8'h55,0, 1, 0, 0, 8'h00, 0, 0, 0, 2, 2);
        add(8'hFD,1, 1, 0, 1, 8'h55, 1, 1, 0, 3, 2);
        add(8'hFB,1, 1, 0, 0, 8'h00, 0, 0, 0, 3, 2);
        add(8'h66,0, 1, 0, 0, 8'h00, 0, 0, 0, 3, 2);
        add(8'h77,0, 1, 0, 1, 8'h66, 1, 0, 0, 3, 2);
        add(8'h88,0, 0, 0, 1, 8'h77, 0, 1, 1, 3, 3);
        add(8'hFB,1, 1, 0, 0, 8'h00, 0, 0, 0, 3, 3);
        add(8'hFD,1, 1, 0, 0, 8'h00, 0, 0, 0, 3, 4);
        add(8'hFB,1, 1, 0, 0, 8'h00, 0, 0, 0, 3, 4);
        add(8'h1C,1, 1, 0, 0, 8'h00, 0, 0, 0, 3, 5);
        foreach (vecs[i]) begin
            drive(vecs[i].d, vecs[i].k, vecs[i].al, vecs[i].de);
            nchk++;
            if (o_valid !== vecs[i].v || o_frm_cnt != 16'(vecs[i].frm) ||
                o_err_cnt != 16'(vecs[i].errc) ||
                (vecs[i].v && (o_data !== vecs[i].od || o_sop !== vecs[i].sop ||
                               o_eop !== vecs[i].eop || o_err !== vecs[i].err))) begin
                nerr++;
                $display("FAIL vec%0d got v=%b d=%h s=%b e=%b r=%b f=%0d ec=%0d want v=%b d=%h s=%b e=%b r=%b f=%0d ec=%0d",
                         i, o_valid, o_data, o_sop, o_eop, o_err, o_frm_cnt, o_err_cnt,
                         vecs[i].v, vecs[i].od, vecs[i].sop, vecs[i].eop, vecs[i].err,
                         vecs[i].frm, vecs[i].errc);
            end
        end
`else
        pay = '{8'h31, 8'h32, 8'h33};
        c = tb_crc(pay);
        for (int flip = 0; flip < 2; flip++) begin
            drive(SOF_C, 1, 1, 0);
            foreach (pay[i]) drive(pay[i], 0, 1, 0);
            drive(c[15:8], 0, 1, 0);
            drive(flip ? (c[7:0] ^ 8'h04) : c[7:0], 0, 1, 0);
            drive(EOF_C, 1, 1, 0);
            check("crc_eop_data", int'(o_data), 'h33);
            check("crc_eop_err", int'(o_err), flip);
        end
`endif

        // Longest legal frame: every byte comes out, last one carries eop.
        drive(SOF_C, 1, 1, 0);
        beats = 0;
        for (int i = 0; i < TB_MAX_LEN; i++) begin
            drive(8'(i), 0, 1, 0);
            if (o_valid) beats++;
        end
        drive(EOF_C, 1, 1, 0);
        if (o_valid) beats++;
        check("maxlen_beats", beats, TB_MAX_LEN - TB_HD + 1);
        check("maxlen_eop", int'(o_eop), 1);

        // One byte over: abort beat, then everything until the next SOF is ignored.
        e0 = int'(m_errc);
        drive(SOF_C, 1, 1, 0);
        beats = 0;
        last_ok = 0;
        for (int i = 0; i <= TB_MAX_LEN; i++) begin
            drive(8'(i + 3), 0, 1, 0);
            if (o_valid) beats++;
            if (i == TB_MAX_LEN) last_ok = o_valid && o_eop && o_err;
        end
        check("overlen_beats", beats, TB_MAX_LEN - TB_HD + 1);
        check("overlen_abort_beat", int'(last_ok), 1);
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            drive(8'(i), 0, 1, 0);
            if (o_valid) beats++;
        end
        drive(EOF_C, 1, 1, 0);
        if (o_valid) beats++;
        check("overlen_ignored", beats, 0);
        check("overlen_errcnt", int'(o_err_cnt), e0 + 1);

        // Random frames with idles, disparity errors, sync loss and stray K-chars.
        for (int f = 0; f < 400; f++) begin
            pay.delete();
            len = $urandom_range(0, 10);
            drive(SOF_C, 1, 1, 0);
            for (int j = 0; j < len; j++) pay.push_back(8'($urandom));
`ifdef RX_DEFRM_CRC_EN
            c = tb_crc(pay);
            if ($urandom_range(0, 3) == 0) c = c ^ (16'h0001 << $urandom_range(0, 15));
            pay.push_back(c[15:8]);
            pay.push_back(c[7:0]);
`endif
            foreach (pay[j]) begin
                if ($urandom_range(0, 4) == 0) drive(IDLE_C, 1, 1, $urandom_range(0, 9) == 0);
                r = $urandom_range(0, 99);
                if (r < 2) drive(pay[j], 0, 0, 0);
                else if (r < 4) drive(pay[j], 0, 1, 1);
                else if (r < 5) drive(8'h1C, 1, 1, 0);
                else if (r < 6) drive(SOF_C, 1, 1, 0);
                else drive(pay[j], 0, 1, 0);
            end
            if ($urandom_range(0, 9) != 0) drive(EOF_C, 1, 1, 0);
            repeat ($urandom_range(0, 3)) begin
                drive(8'($urandom), 1'($urandom), $urandom_range(0, 4) != 0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
